// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Generates the hard and soft resets for the MSX core. Hard reset requests
// come from PLL loss of lock, the OSD/front-panel hard-reset level, or a disk
// image mount when "Hard reset after Mount" is enabled. Soft reset requests
// come from the OSD soft-reset level. Each reset is held for a fixed number
// of clk_sys cycles after the last request. A hard request always wins over
// a soft one.
//
// Parameters
//   HARD_CYCLES    hard-reset hold length in clk_sys cycles
//   SOFT_CYCLES    soft-reset hold length in clk_sys cycles
//
// Ports
//   clk_sys        core master clock (only clock)
//   reset          synchronous active-high block reset
//   pll_locked_i   PLL lock, asynchronous; low requests a hard reset
//   hard_req_i     OSD hard-reset level OR front-panel button
//   soft_req_i     OSD soft-reset level
//   img_mounted_i  per-drive mount strobes, asynchronous
//   mount_rst_en_i "Hard reset after Mount" option
//   hard_reset_o   registered hard reset to the core
//   soft_reset_o   registered soft reset to the core
//   busy_o         high whenever a reset is being held
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int HARD_CYCLES = 21477,
  parameter int SOFT_CYCLES = 2148
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked_i,
  input  logic       hard_req_i,
  input  logic       soft_req_i,
  input  logic [1:0] img_mounted_i,
  input  logic       mount_rst_en_i,
  output logic       hard_reset_o,
  output logic       soft_reset_o,
  output logic       busy_o
);

  localparam int MAX_CYCLES = (HARD_CYCLES > SOFT_CYCLES) ? HARD_CYCLES : SOFT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] HARD_LOAD = CNT_W'(HARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HARD_HOLD = 2'd1,
    SOFT_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers. pll_locked clears to 0 on reset so the block keeps
  // requesting a hard reset until lock has been seen through both flops.
  // ---------------------------------------------------------------------
  logic pll_meta_reg, pll_sync_reg;
  logic hard_meta_reg, hard_sync_reg;
  logic soft_meta_reg, soft_sync_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pll_meta_reg  <= 1'b0;
      pll_sync_reg  <= 1'b0;
      hard_meta_reg <= 1'b0;
      hard_sync_reg <= 1'b0;
      soft_meta_reg <= 1'b0;
      soft_sync_reg <= 1'b0;
    end else begin
      pll_meta_reg  <= pll_locked_i;
      pll_sync_reg  <= pll_meta_reg;
      hard_meta_reg <= hard_req_i;
      hard_sync_reg <= hard_meta_reg;
      soft_meta_reg <= soft_req_i;
      soft_sync_reg <= soft_meta_reg;
    end
  end

  // Per-drive mount strobe: 2-flop sync plus a previous-value register for
  // rising-edge detection. A strobe held high yields a single edge.
  logic [1:0] img_rise;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_img_sync
      logic meta_reg, sync_reg, prev_reg;

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= img_mounted_i[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign img_rise[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  // Mount event is registered once more, so a mount reaches the state
  // register one cycle later than the level requests.
  logic mount_evt_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mount_evt_reg <= 1'b0;
    end else begin
      mount_evt_reg <= mount_rst_en_i & (|img_rise);
    end
  end

  logic hard_lvl;
  logic hard_trig;

  assign hard_lvl  = ~pll_sync_reg | hard_sync_reg;
  assign hard_trig = hard_lvl | mount_evt_reg;

  // ---------------------------------------------------------------------
  // Hold FSM
  // ---------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hard_reset_reg, soft_reset_reg, busy_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= HARD_HOLD;
      cnt_reg        <= HARD_LOAD;
      hard_reset_reg <= 1'b1;
      soft_reset_reg <= 1'b0;
      busy_reg       <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      // Outputs are decoded from the next state so they are plain flops
      // that track the state register exactly.
      hard_reset_reg <= (state_next == HARD_HOLD);
      soft_reset_reg <= (state_next == SOFT_HOLD);
      busy_reg       <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (hard_trig) begin
          state_next = HARD_HOLD;
          cnt_next   = HARD_LOAD;
        end else if (soft_sync_reg) begin
          state_next = SOFT_HOLD;
          cnt_next   = SOFT_LOAD;
        end
      end
      HARD_HOLD: begin
        // Soft requests are dropped here; nothing is queued for later.
        if (hard_trig) begin
          cnt_next = HARD_LOAD;
        end else if (cnt_reg == CNT_ZERO) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      SOFT_HOLD: begin
        if (hard_trig) begin
          state_next = HARD_HOLD;
          cnt_next   = HARD_LOAD;
        end else if (soft_sync_reg) begin
          cnt_next = SOFT_LOAD;
        end else if (cnt_reg == CNT_ZERO) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        // Unreachable encoding: recover into a full hard reset.
        state_next = HARD_HOLD;
        cnt_next   = HARD_LOAD;
      end
    endcase
  end

  assign hard_reset_o = hard_reset_reg;
  assign soft_reset_o = soft_reset_reg;
  assign busy_o       = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int HC = 8;
  localparam int SC = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       pll_locked_i;
  logic       hard_req_i;
  logic       soft_req_i;
  logic [1:0] img_mounted_i;
  logic       mount_rst_en_i;
  logic       hard_reset_o;
  logic       soft_reset_o;
  logic       busy_o;

  reset_sequencer #(
    .HARD_CYCLES(HC),
    .SOFT_CYCLES(SC)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .pll_locked_i  (pll_locked_i),
    .hard_req_i    (hard_req_i),
    .soft_req_i    (soft_req_i),
    .img_mounted_i (img_mounted_i),
    .mount_rst_en_i(mount_rst_en_i),
    .hard_reset_o  (hard_reset_o),
    .soft_reset_o  (soft_reset_o),
    .busy_o        (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  // -------------------------------------------------------------------
  // Reference model: timestamps. Each input is seen by the hold logic a
  // fixed number of edges later (2 for levels, 3 for mount edges). A hard
  // request seen at edge t keeps hard reset up through edge t+HC-1; a soft
  // request accepted at edge t keeps soft reset up through edge t+SC-1.
  // -------------------------------------------------------------------
  int t = 0;
  int hard_until = 0;
  int soft_until = 0;
  bit [2:0] pll_hist, hard_hist, soft_hist;   // index 0 = newest
  bit [1:0] img_hist [0:2];
  bit       mevt_hist;

  task automatic model_edge();
    bit hr;
    bit hw;
    t++;
    if (reset) begin
      pll_hist   = '0;
      hard_hist  = '0;
      soft_hist  = '0;
      img_hist[0] = '0;
      img_hist[1] = '0;
      img_hist[2] = '0;
      mevt_hist  = 1'b0;
      hard_until = t + HC;
      soft_until = 0;
    end else begin
      hr = !pll_hist[1] || hard_hist[1] || mevt_hist;
      hw = (t - 1) < hard_until;
      if (hr) begin
        hard_until = t + HC;
        soft_until = 0;
      end else if (soft_hist[1] && !hw) begin
        soft_until = t + SC;
      end
      mevt_hist   = mount_rst_en_i && ((img_hist[1] & ~img_hist[2]) != 2'b00);
      img_hist[2] = img_hist[1];
      img_hist[1] = img_hist[0];
      img_hist[0] = img_mounted_i;
      pll_hist    = {pll_hist[1:0], pll_locked_i};
      hard_hist   = {hard_hist[1:0], hard_req_i};
      soft_hist   = {soft_hist[1:0], soft_req_i};
    end
  endtask

  task automatic step();
    bit eh, es, eb;
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    eh = t < hard_until;
    es = !eh && (t < soft_until);
    eb = eh || es;
    n_tests++;
    if (hard_reset_o !== eh || soft_reset_o !== es || busy_o !== eb) begin
      n_fail++;
      $display("FAIL model_cycle t=%0d got hard/soft/busy=%b/%b/%b expected %b/%b/%b",
               t, hard_reset_o, soft_reset_o, busy_o, eh, es, eb);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    reset          = 1'b0;
    pll_locked_i   = 1'b1;
    hard_req_i     = 1'b0;
    soft_req_i     = 1'b0;
    img_mounted_i  = 2'b00;
    mount_rst_en_i = 1'b1;
  endtask

  // Stimulus for case 'kind' before edge k (k starts at 1).
  task automatic drive(input int kind, input int k);
    drive_idle();
    case (kind)
      0: soft_req_i = (k == 1);
      1: hard_req_i = (k == 1);
      2: pll_locked_i = (k != 1);
      3: img_mounted_i = (k <= 20) ? 2'b01 : 2'b00;
      4: img_mounted_i = (k <= 20) ? 2'b10 : 2'b00;
      5: begin
        mount_rst_en_i = 1'b0;
        img_mounted_i  = (k <= 20) ? 2'b01 : 2'b00;
      end
      6: begin
        hard_req_i = (k <= 30);
        soft_req_i = (k == 10);
      end
      7: begin
        hard_req_i = (k == 1);
        soft_req_i = (k == 1);
      end
      8: begin
        soft_req_i = (k == 1);
        hard_req_i = (k == 3);
      end
      default: ;
    endcase
  endtask

  task automatic run_case(input int kind, output int hs, output int hl,
                          output int ss, output int sl);
    hs = -1; hl = 0; ss = -1; sl = 0;
    for (int k = 1; k <= 50; k++) begin
      drive(kind, k);
      step();
      if (hard_reset_o === 1'b1) begin
        if (hs < 0) hs = k;
        hl++;
      end
      if (soft_reset_o === 1'b1) begin
        if (ss < 0) ss = k;
        sl++;
      end
    end
    drive_idle();
  endtask

  typedef struct {
    string name;
    int    kind;
    int    hs, hl, ss, sl;   // expected start cycle / length, -1 = never
  } vec_t;

  vec_t vecs [9];

  initial begin
    int hs, hl, ss, sl;
    int cnt;

    vecs[0] = '{"soft_pulse",     0, -1,  0,  3, 4};
    vecs[1] = '{"hard_pulse",     1,  3,  8, -1, 0};
    vecs[2] = '{"pll_drop",       2,  3,  8, -1, 0};
    vecs[3] = '{"mount_drive0",   3,  4,  8, -1, 0};
    vecs[4] = '{"mount_drive1",   4,  4,  8, -1, 0};
    vecs[5] = '{"mount_disabled", 5, -1,  0, -1, 0};
    vecs[6] = '{"hard_level",     6,  3, 37, -1, 0};
    vecs[7] = '{"soft_hard_same", 7,  3,  8, -1, 0};
    vecs[8] = '{"upgrade",        8,  5,  8,  3, 2};

    // Power-up: one reset cycle, PLL locked from the start.
    drive_idle();
    reset = 1'b1;
    step();
    check("reset_hard", int'(hard_reset_o), 1);
    check("reset_soft", int'(soft_reset_o), 0);
    check("reset_busy", int'(busy_o), 1);
    reset = 1'b0;
    cnt = 1;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (hard_reset_o === 1'b1) cnt++;
    end
    check("powerup_hard_len", cnt, 10);
    check("powerup_busy_end", int'(busy_o), 0);

    // Directed table.
    foreach (vecs[i]) begin
      run_case(vecs[i].kind, hs, hl, ss, sl);
      check({vecs[i].name, "_hard_start"}, hs, vecs[i].hs);
      check({vecs[i].name, "_hard_len"},   hl, vecs[i].hl);
      check({vecs[i].name, "_soft_start"}, ss, vecs[i].ss);
      check({vecs[i].name, "_soft_len"},   sl, vecs[i].sl);
      for (int k = 0; k < 10; k++) step();
    end

    // Reset asserted while soft reset is being held.
    drive_idle();
    soft_req_i = 1'b1;
    step();
    soft_req_i = 1'b0;
    step();
    step();
    check("midsoft_soft_up", int'(soft_reset_o), 1);
    reset = 1'b1;
    step();
    check("midsoft_hard_now", int'(hard_reset_o), 1);
    check("midsoft_soft_now", int'(soft_reset_o), 0);
    reset = 1'b0;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hard_reset_o === 1'b1) cnt++;
    end
    check("midsoft_hard_len", cnt, 10);

    // Randomized run against the model.
    drive_idle();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      pll_locked_i = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 9) == 0) hard_req_i = ($urandom_range(0, 5) == 0);
      soft_req_i   = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 29) == 0)
        img_mounted_i[$urandom_range(0, 1)] = ~img_mounted_i[$urandom_range(0, 1)];
      if ($urandom_range(0, 99) == 0) mount_rst_en_i = ~mount_rst_en_i;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HARD_CYCLES, default 21477, hard-reset hold length in clk_sys cycles (1 ms at 21.477 MHz).
REQ-002 SHALL have parameter SOFT_CYCLES, default 2148, soft-reset hold length in clk_sys cycles.
REQ-003 SHALL have port clk_sys  in  1  core master clock; the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high block reset.
REQ-005 SHALL have port pll_locked_i  in  1  PLL lock, asynchronous; low = hard request.
REQ-006 SHALL have port hard_req_i  in  1  OSD hard-reset level (status[0]) OR front-panel button.
REQ-007 SHALL have port soft_req_i  in  1  OSD soft-reset level (status[1]).
REQ-008 SHALL have port img_mounted_i  in  2  per-drive mount strobes, asynchronous to clk_sys.
REQ-009 SHALL have port mount_rst_en_i  in  1  "Hard reset after Mount" OSD option.
REQ-010 SHALL have port hard_reset_o  out  1  registered hard reset to the MSX core.
REQ-011 SHALL have port soft_reset_o  out  1  registered soft reset to the MSX core.
REQ-012 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass pll_locked_i, hard_req_i, soft_req_i and each img_mounted_i bit through a 2-flop synchronizer; all further references are to synchronized values.
REQ-014 SHALL form hard_lvl = !pll_locked OR hard_req; SHALL form mount_evt = mount_rst_en_i AND rising edge of any synchronized img_mounted bit (edge detector register, 1-cycle pulse).
REQ-015 SHALL implement states IDLE, HARD_HOLD, SOFT_HOLD.
REQ-016 SHALL use a down-counter of width $clog2(max(HARD_CYCLES,SOFT_CYCLES)+1).
REQ-017 IDLE: hard_lvl or mount_evt -> HARD_HOLD, counter = HARD_CYCLES-1; else soft_req -> SOFT_HOLD, counter = SOFT_CYCLES-1; hard takes priority on simultaneous requests.
REQ-018 HARD_HOLD: while hard_lvl=1 or mount_evt=1 the counter SHALL reload HARD_CYCLES-1; otherwise decrement; at counter=0 with no request -> IDLE.
REQ-019 SOFT_HOLD: hard_lvl or mount_evt SHALL upgrade to HARD_HOLD with counter = HARD_CYCLES-1; soft_req=1 reloads SOFT_CYCLES-1; otherwise decrement; at 0 -> IDLE.
REQ-020 soft_req in HARD_HOLD SHALL be ignored (no queued soft reset afterwards).
REQ-021 hard_reset_o SHALL be 1 exactly when state register = HARD_HOLD; soft_reset_o exactly when = SOFT_HOLD; never both high.
REQ-022 From a one-cycle request pulse (post-synchronizer) the output SHALL assert the next cycle and stay high exactly HARD_CYCLES (resp. SOFT_CYCLES) cycles.
REQ-023 Input-to-output latency SHALL be 3 clk_sys cycles (2 sync + 1 state register) for level inputs; 4 for img_mounted (extra edge register).
REQ-024 Counter SHALL not wrap: decrement occurs only when counter > 0.
REQ-025 img_mounted held high SHALL produce only one mount_evt; a falling edge produces none.

Reset
REQ-026 reset=1 SHALL force state HARD_HOLD, counter = HARD_CYCLES-1, synchronizer and edge registers to 0 (pll_locked sync to 0), hard_reset_o=1, soft_reset_o=0, busy_o=1 on the next edge.
REQ-027 reset asserted mid-SOFT_HOLD SHALL replace soft with hard reset on the next edge; after release, hard_reset_o SHALL remain high at least HARD_CYCLES cycles after pll_locked sync returns high.

Verification (HARD_CYCLES=8, SOFT_CYCLES=4)
REQ-028 Power-up: reset 1 cycle, pll_locked_i high from start -> hard_reset_o high until pll_locked synced plus 8 cycles, then 0; busy_o follows.
REQ-029 Soft pulse: soft_req_i high 1 cycle in IDLE -> soft_reset_o high 3 cycles later for exactly 4 cycles; hard_reset_o stays 0.
REQ-030 Upgrade: soft_req_i pulse, then hard_req_i pulse 2 cycles later -> soft_reset_o drops same edge hard_reset_o rises; hard held 8 cycles after the request pulse ends.
REQ-031 Mount: mount_rst_en_i=1, img_mounted_i=2'b01 held 20 cycles -> one 8-cycle hard pulse starting 4 cycles after edge; repeat with mount_rst_en_i=0 -> no output.
REQ-032 Level hold: hard_req_i high 30 cycles -> hard_reset_o high throughout and 8 cycles beyond synced release; soft_req_i pulse during it produces no soft_reset_o.
REQ-033 pll_locked_i drop for 1 cycle in IDLE -> 8-cycle hard_reset_o pulse, soft_reset_o never high.
